// File: rtl/bnn_pkg.sv
// Shared sizes, FSM encoding and the signed max helper for the binary network datapath.
package bnn_pkg;

   localparam int DW   = 32;
   localparam int W0   = 24;
   localparam int W1   = 8;
   localparam int BUFD = 12;
   localparam int P0   = W0 / 2;
   localparam int P1   = W1 / 2;
   localparam int CW   = $clog2(W0);
   localparam int AW   = $clog2(BUFD);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pool_state_e;

   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
      return (a >= b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Half-width row buffer holding the horizontal maxima of the even input row.
module pool_row_buf
   import bnn_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [BUFD];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BUFD; i++) mem[i] <= '0;
      end else if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/maxpool2x2.sv
// Streaming 2x2 stride-2 max-pool with sign binarization, fed by the conv stage raster output.
module maxpool2x2
   import bnn_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          state,
   input  logic [DW-1:0] din,
   input  logic          ivalid,
   input  logic          idone,
   output logic [DW-1:0] dout,
   output logic          dout_bin,
   output logic          ovalid,
   output logic          done,
   output logic          err
);

   localparam logic [CW-1:0] LAST0 = CW'(2 * P0 - 1);
   localparam logic [CW-1:0] LAST1 = CW'(2 * P1 - 1);

   pool_state_e             cur_st, nxt_st;
   logic                    layer_q;
   logic                    eff_layer;
   logic [CW-1:0]           col, row, last_idx;
   logic                    col_wrap, is_final, abort, buf_we;
   logic signed [DW-1:0]    pair, hmax, vmax;
   logic [DW-1:0]           buf_rd;

   // The layer select only matters on the first sample; afterwards the latched copy rules.
   assign eff_layer = (cur_st == IDLE) ? state : layer_q;
   assign last_idx  = eff_layer ? LAST1 : LAST0;
   assign col_wrap  = (col == last_idx);
   assign is_final  = col_wrap && (row == last_idx);
   assign abort     = ivalid && idone && !is_final;
   assign hmax      = smax(pair, din);
   assign vmax      = smax(buf_rd, hmax);
   assign buf_we    = ivalid && col[0] && !row[0];

   pool_row_buf u_row_buf (
      .clk   (clk),
      .rstn  (rstn),
      .we    (buf_we),
      .idx   (AW'(col >> 1)),
      .wdata (hmax),
      .rdata (buf_rd)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cur_st <= IDLE;
      else       cur_st <= nxt_st;
   end

   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         IDLE: if (ivalid && !abort) nxt_st = RUN;
         RUN:  if (ivalid && (is_final || abort)) nxt_st = IDLE;
         default: nxt_st = IDLE;
      endcase
   end

   // Counters and pooling datapath; a premature idone throws the frame away and rearms.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         layer_q  <= 1'b0;
         col      <= '0;
         row      <= '0;
         pair     <= '0;
         dout     <= '0;
         dout_bin <= 1'b0;
         ovalid   <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         ovalid <= 1'b0;
         done   <= 1'b0;
         if (ivalid) begin
            if (cur_st == IDLE) layer_q <= state;
            if (!col[0]) pair <= din;
            if (col[0] && row[0]) begin
               dout     <= vmax;
               dout_bin <= ~vmax[DW-1];
               ovalid   <= 1'b1;
               done     <= is_final;
            end
            if (abort || (is_final && !idone)) err <= 1'b1;
            if (abort) begin
               col <= '0;
               row <= '0;
            end else if (col_wrap) begin
               col <= '0;
               row <= is_final ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool2x2.sv
// Directed self-checking bench for maxpool2x2: ramps, signed windows, gaps, resets and framing errors.
module tb_maxpool2x2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        state;
   logic [31:0] din;
   logic        ivalid;
   logic        idone;
   logic [31:0] dout;
   logic        dout_bin;
   logic        ovalid;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   maxpool2x2 dut (
      .clk      (clk),
      .rstn     (rstn),
      .state    (state),
      .din      (din),
      .ivalid   (ivalid),
      .idone    (idone),
      .dout     (dout),
      .dout_bin (dout_bin),
      .ovalid   (ovalid),
      .done     (done),
      .err      (err)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One input sample, then the registered output is inspected just after that same edge.
   task automatic apply_stimulus(input logic [31:0] d, input logic id, input logic exp_v,
                                 input logic [31:0] exp_d, input logic exp_done);
      logic [31:0] e;
      @(negedge clk);
      din    = d;
      ivalid = 1'b1;
      idone  = id;
      @(posedge clk);
      #1;
      e = exp_d;
      check_output("ovalid", {31'd0, ovalid}, {31'd0, exp_v});
      if (exp_v) begin
         check_output("dout", dout, e);
         check_output("dout_bin", {31'd0, dout_bin}, {31'd0, ~e[31]});
         check_output("done", {31'd0, done}, {31'd0, exp_done});
      end else begin
         check_output("done_idle", {31'd0, done}, 32'd0);
      end
      ivalid = 1'b0;
      idone  = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      ivalid = 1'b0;
      idone  = 1'b0;
      @(posedge clk);
      #1;
      check_output("ovalid_gap", {31'd0, ovalid}, 32'd0);
   endtask

   // mode 0: ramp r*w+c; mode 1: alternating signed windows with maxima -1 and 0.
   task automatic run_frame(input int w, input logic layer, input int mode, input bit gaps,
                            input int n_samples, input int idone_at);
      int          outs;
      logic [31:0] first_v, last_v;
      int          r, c;
      logic [31:0] v, ev;
      logic        ov;
      int          tblA [4] = '{-5, -9, -1, -7};
      int          tblB [4] = '{-3, 0, -8, -2};
      outs = 0;
      first_v = '0;
      last_v  = '0;
      for (int idx = 0; idx < n_samples; idx++) begin
         r = idx / w;
         c = idx % w;
         if (gaps) repeat ($urandom_range(0, 1)) idle_cycle();
         if (idx == 0) state = layer;
         else if (gaps) state = 1'($urandom_range(0, 1));
         if (mode == 0) begin
            v  = idx;
            ev = idx;
         end else begin
            v  = ((c / 2) % 2 == 0) ? tblA[(r % 2) * 2 + (c % 2)] : tblB[(r % 2) * 2 + (c % 2)];
            ev = ((c / 2) % 2 == 0) ? 32'hFFFF_FFFF : 32'd0;
         end
         ov = (r % 2 == 1) && (c % 2 == 1);
         apply_stimulus(v, idx == idone_at, ov, ev, idx == w * w - 1);
         if (ov) begin
            if (outs == 0) first_v = dout;
            last_v = dout;
            outs++;
         end
      end
      if (n_samples == w * w) begin
         check_output("out_count", outs, (w / 2) * (w / 2));
         if (mode == 0) begin
            check_output("first_out", first_v, w + 1);
            check_output("last_out", last_v, w * w - 1);
         end
      end
   endtask

   initial begin
      rstn   = 1'b0;
      state  = 1'b0;
      din    = '0;
      ivalid = 1'b0;
      idone  = 1'b0;
      #12;
      check_output("rst_dout", dout, 32'd0);
      check_output("rst_bin", {31'd0, dout_bin}, 32'd0);
      check_output("rst_ovalid", {31'd0, ovalid}, 32'd0);
      check_output("rst_done", {31'd0, done}, 32'd0);
      check_output("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      run_frame(24, 1'b0, 0, 1'b0, 576, 575);
      run_frame(8, 1'b1, 0, 1'b0, 64, 63);
      check_output("err_clean", {31'd0, err}, 32'd0);

      run_frame(24, 1'b0, 1, 1'b0, 576, 575);
      run_frame(24, 1'b0, 0, 1'b1, 576, 575);
      check_output("err_clean2", {31'd0, err}, 32'd0);

      run_frame(24, 1'b0, 0, 1'b0, 300, -1);
      #2;
      rstn = 1'b0;
      #1;
      check_output("arst_dout", dout, 32'd0);
      check_output("arst_bin", {31'd0, dout_bin}, 32'd0);
      check_output("arst_ovalid", {31'd0, ovalid}, 32'd0);
      check_output("arst_done", {31'd0, done}, 32'd0);
      check_output("arst_err", {31'd0, err}, 32'd0);
      @(posedge clk);
      #2;
      rstn = 1'b1;
      run_frame(8, 1'b1, 0, 1'b0, 64, 63);

      run_frame(24, 1'b0, 0, 1'b0, 100, 99);
      check_output("err_abort", {31'd0, err}, 32'd1);
      idle_cycle();
      run_frame(24, 1'b0, 0, 1'b0, 576, 575);
      check_output("err_sticky", {31'd0, err}, 32'd1);

      @(negedge clk);
      rstn = 1'b0;
      #1;
      check_output("err_cleared", {31'd0, err}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      run_frame(8, 1'b1, 0, 1'b0, 64, -1);
      check_output("err_missing_idone", {31'd0, err}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/maxpool2x2.md
Name: maxpool2x2

Overview:
- Streaming 2x2/stride-2 max-pool plus sign binarization stage, directly downstream of the conv stage.
- Consumes conv's raster-ordered signed 32-bit results (dout/ovalid/done).
- Emits the pooled map (24x24->12x12 for layer 0, 8x8->4x4 for layer 1) with a 1-bit binarized copy for the next binary conv/FC layer.
- Uses one half-width row buffer; no full-frame storage.

Parameters:
- DW, 32: data width of conv results and pooled output.
- W0, 24: input map width/height when state=0.
- W1, 8: input map width/height when state=1.
- BUFD, 12: row-buffer depth; must be >= W0/2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- state  in  1  layer select: 0 = W0 map, 1 = W1 map; latched at frame start.
- din  in  DW  signed conv result.
- ivalid  in  1  din valid (conv ovalid).
- idone  in  1  conv done; high together with the last ivalid of a frame.
- dout  out  DW  signed pooled maximum.
- dout_bin  out  1  binarized output: ~dout[DW-1], so 1 when dout >= 0.
- ovalid  out  1  dout/dout_bin valid, one-cycle pulse per pooled pixel.
- done  out  1  high with the last ovalid of a frame.
- err  out  1  sticky frame-length mismatch flag.

Behaviour:
- Reset (rstn=0, async): dout=0, dout_bin=0, ovalid=0, done=0, err=0; col/row counters=0, pair register and row buffer cleared, FSM=IDLE.
- FSM states:
  - IDLE: waits for ivalid. On the first ivalid, latches W = state ? W1 : W0, processes that sample, and goes to RUN.
  - RUN: processes each ivalid sample. Returns to IDLE after the final sample (row=W-1, col=W-1).
- state is ignored while in RUN; a change mid-frame has no effect.
- Counters:
  - col increments on each ivalid and wraps at W-1.
  - row increments on col wrap.
  - Cycles with ivalid=0 hold all state; arbitrary gaps are legal.
- Pooling datapath:
  - Even col: register din as the pair value.
  - Odd col: hmax = signed max(pair, din).
  - Even row: write hmax to buf[col>>1].
  - Odd row: vmax = signed max(buf[col>>1], hmax), registered to dout. ovalid=1 on the next cycle.
- Latency: exactly 1 clock from the ivalid sample at (odd row, odd col) to ovalid.
- Throughput: one input per clock sustained; (W/2)^2 outputs per frame (144 or 16).
- Comparison: signed DW-bit. On a tie either operand is returned (values equal). No width growth.
- done: asserted in the same cycle as the ovalid for the final window (row W-1, col W-1), derived from internal counters, not from idone.
- err (sticky until reset):
  - Set when idone=1 with ivalid at a position other than the final one. Counters are also cleared to 0 and the FSM returns to IDLE; no done is generated.
  - Set when the final sample arrives with idone=0. The frame still completes normally and done is asserted.
- idone without ivalid is ignored.
- Back-to-back frames: a first sample of the next frame in the cycle right after the final sample is accepted with no bubble.
- Reset mid-frame discards the partial frame; no output is produced for it.

Decomposition:
- Shared package bnn_pkg holds:
  - DW, W0, W1, BUFD, with derived pooled sizes P0=12 and P1=4;
  - counter width localparam CW = $clog2(W0);
  - FSM state encoding (IDLE, RUN);
  - signed max function smax(a,b).
- One sub-module, pool_row_buf: BUFD x DW register array with one write port and one combinational read port, async clear on rstn. Index = col>>1, write enable = ivalid & odd col & even row.

Test Plan:
- state=0 ramp, din=row*24+col, continuous ivalid with idone on sample 576:
  - 144 ovalid pulses; out[i][j]=(2i+1)*24+2j+1; first 25, last 575;
  - done coincident with the 144th pulse; err=0.
- state=1 ramp, din=row*8+col, 64 samples: 16 outputs; first 9, last 63; done on the 16th pulse.
- state=0 signed data: each window {-5,-9,-1,-7} -> dout=-1, dout_bin=0; each window {-3,0,-8,-2} -> dout=0, dout_bin=1.
- ivalid randomly deasserted 50% of cycles during a state=0 ramp: identical 144 outputs, each ovalid exactly 1 cycle after its (odd,odd) sample; state toggled mid-frame has no effect.
- rstn low for 1 cycle after 300 inputs: all outputs 0 immediately (async); the following full state=1 frame gives the 9..63 sequence correctly.
- idone pulsed with input #100 of a state=0 frame: err=1, no done. The next full frame produces correct outputs and done; err stays 1 until reset.
